// File: rtl/adc_sample_averager.sv
// Averages 2**N_LOG2 strobed ADC samples with round-half-up and queues each
// result in a small FIFO with a sticky overflow flag.
module adc_sample_averager #(
    parameter int N_LOG2     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstp,
    input  logic       en,
    input  logic [3:0] adc_in,
    input  logic       sample_valid,
    output logic [3:0] avg_out,
    output logic       avg_valid,
    input  logic       avg_ready,
    output logic [4:0] fifo_count,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int SW  = 4 + N_LOG2;
    localparam int CW  = (N_LOG2 > 0) ? N_LOG2 : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RND = (1 << N_LOG2) >> 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic [SW:0]   total;
    logic [3:0]    result;
    logic          last_sample;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic [4:0]    count_next;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_comb begin
        // With N_LOG2 = 0 every sample closes a group and cnt stays at zero.
        last_sample = (N_LOG2 == 0) ? 1'b1 : (cnt == '1);
        total       = {1'b0, sum} + (SW+1)'(adc_in) + (SW+1)'(RND);
        result      = 4'(total >> N_LOG2);
        push_req    = (state == ACCUM) && en && sample_valid && last_sample;
        do_pop      = avg_valid && avg_ready;
        do_push     = push_req && ((fifo_count != DEPTH_C) || do_pop);
        count_next  = fifo_count;
        if (do_push && !do_pop)
            count_next = fifo_count + 5'd1;
        else if (do_pop && !do_push)
            count_next = fifo_count - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sum <= '0;
                    cnt <= '0;
                    if (en)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (!en) begin
                        state <= IDLE;
                        sum   <= '0;
                        cnt   <= '0;
                    end else if (sample_valid) begin
                        if (last_sample) begin
                            sum <= '0;
                            cnt <= '0;
                        end else begin
                            sum <= sum + SW'(adc_in);
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstp && do_push)
            mem[wr_ptr] <= result;
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            avg_valid  <= 1'b0;
            avg_out    <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            avg_valid  <= (count_next != 5'd0);
            // avg_out is a register tracking the head so it holds its last value once empty.
            if (do_pop) begin
                if (fifo_count > 5'd1)
                    avg_out <= mem[rd_ptr + 1'b1];
                else if (do_push)
                    avg_out <= result;
            end else if (fifo_count == 5'd0 && do_push) begin
                avg_out <= result;
            end
            if (push_req && !do_push)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench: table of sample groups plus directed FIFO, enable and
// reset sequences, with a scoreboard checking every popped result in order.
module tb_adc_sample_averager;

    logic       clk = 1'b0;
    logic       rstp;
    logic       en;
    logic [3:0] adc_in;
    logic       sample_valid;
    logic [3:0] avg_out;
    logic       avg_valid;
    logic       avg_ready;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    typedef struct packed {
        logic [3:0][3:0] s;
        logic [3:0]      exp;
    } vec_t;

    vec_t vecs[9];

    adc_sample_averager #(.N_LOG2(2), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rstp         (rstp),
        .en           (en),
        .adc_in       (adc_in),
        .sample_valid (sample_valid),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] v);
        adc_in       = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic group(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            strobe(v);
    endtask

    // Pops happen at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (rstp === 1'b0 && avg_valid === 1'b1 && avg_ready === 1'b1) begin
            if (sb.size() == 0)
                check("sb_unexpected_pop", int'(avg_out), -1);
            else
                check("sb_order", int'(avg_out), sb.pop_front());
        end
    end

    initial begin
        vecs[0] = '{s: {4'd15, 4'd15, 4'd15, 4'd15}, exp: 4'd15};
        vecs[1] = '{s: {4'd0,  4'd0,  4'd0,  4'd0},  exp: 4'd0};
        vecs[2] = '{s: {4'd1,  4'd1,  4'd1,  4'd2},  exp: 4'd1};
        vecs[3] = '{s: {4'd3,  4'd4,  4'd5,  4'd6},  exp: 4'd5};
        vecs[4] = '{s: {4'd7,  4'd8,  4'd9,  4'd9},  exp: 4'd8};
        vecs[5] = '{s: {4'd15, 4'd15, 4'd15, 4'd14}, exp: 4'd15};
        vecs[6] = '{s: {4'd1,  4'd2,  4'd2,  4'd2},  exp: 4'd2};
        vecs[7] = '{s: {4'd0,  4'd0,  4'd0,  4'd1},  exp: 4'd0};
        vecs[8] = '{s: {4'd0,  4'd0,  4'd1,  4'd1},  exp: 4'd1};

        rstp = 1'b1; en = 1'b0; adc_in = '0; sample_valid = 1'b0;
        avg_ready = 1'b0; clr_ovf = 1'b0;
        step(); step();
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_avg_out", int'(avg_out), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_overflow", int'(overflow), 0);
        rstp = 1'b0;

        en = 1'b1;
        step();
        strobe(4'd3); strobe(4'd4); strobe(4'd5);
        check("latency_pre_valid", int'(avg_valid), 0);
        strobe(4'd6);
        check("basic_valid", int'(avg_valid), 1);
        check("basic_out", int'(avg_out), 5);
        check("basic_count", int'(fifo_count), 1);
        sb.push_back(5);
        avg_ready = 1'b1;
        step();
        avg_ready = 1'b0;
        check("pop_valid_low", int'(avg_valid), 0);
        check("pop_count", int'(fifo_count), 0);
        check("pop_hold_out", int'(avg_out), 5);
        step();
        check("empty_ready_count", int'(fifo_count), 0);

        avg_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            for (int j = 3; j >= 0; j--)
                strobe(vecs[i].s[j]);
            sb.push_back(int'(vecs[i].exp));
            check("vec_valid", int'(avg_valid), 1);
            check("vec_out", int'(avg_out), int'(vecs[i].exp));
        end
        step(); step();
        check("vec_drained", sb.size(), 0);

        avg_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            group(4'(v));
            sb.push_back(v);
        end
        check("full_count", int'(fifo_count), 4);
        check("full_no_ovf", int'(overflow), 0);
        group(4'd5);
        check("drop_count", int'(fifo_count), 4);
        check("drop_ovf", int'(overflow), 1);
        avg_ready = 1'b1;
        repeat (5) step();
        avg_ready = 1'b0;
        check("drop_drained", sb.size(), 0);
        check("drop_empty", int'(fifo_count), 0);
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        for (int v = 9; v <= 12; v++) begin
            group(4'(v));
            sb.push_back(v);
        end
        strobe(4'd13); strobe(4'd13); strobe(4'd13);
        avg_ready = 1'b1;
        strobe(4'd13);
        avg_ready = 1'b0;
        sb.push_back(13);
        check("pushpop_full_count", int'(fifo_count), 4);
        check("pushpop_full_ovf", int'(overflow), 0);
        avg_ready = 1'b1;
        repeat (5) step();
        avg_ready = 1'b0;
        check("pushpop_drained", sb.size(), 0);

        for (int v = 1; v <= 4; v++) begin
            group(4'(v));
            sb.push_back(v);
        end
        strobe(4'd6); strobe(4'd6); strobe(4'd6);
        clr_ovf = 1'b1;
        strobe(4'd6);
        clr_ovf = 1'b0;
        check("clr_vs_drop_ovf", int'(overflow), 1);
        avg_ready = 1'b1;
        repeat (5) step();
        check("clr_vs_drop_drained", sb.size(), 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        strobe(4'd3); strobe(4'd3);
        en = 1'b0;
        strobe(4'd15);
        strobe(4'd15);
        en = 1'b1;
        step();
        group(4'd8);
        sb.push_back(8);
        check("en_restart_out", int'(avg_out), 8);
        step(); step();
        check("en_restart_drained", sb.size(), 0);
        check("en_restart_empty", int'(fifo_count), 0);

        avg_ready = 1'b0;
        group(4'd7);
        strobe(4'd15); strobe(4'd15);
        rstp = 1'b1;
        avg_ready = 1'b1;
        clr_ovf = 1'b1;
        step();
        rstp = 1'b0;
        clr_ovf = 1'b0;
        sb.delete();
        check("midrst_valid", int'(avg_valid), 0);
        check("midrst_count", int'(fifo_count), 0);
        check("midrst_out", int'(avg_out), 0);
        step();
        group(4'd2);
        sb.push_back(2);
        check("postrst_out", int'(avg_out), 2);
        step(); step();
        check("postrst_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
